sync_fifo_flags: RTL



---
 rtl/sync_fifo_flags_pkg.sv | 21 ++
 rtl/sync_fifo_flags_ptr.sv | 29 ++
 rtl/sync_fifo_flags.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_pkg.sv
// sync_fifo_pkg: shared operation encoding and count-width helper for sync_fifo_flags.
// Revision 1.0
`default_nettype none

package sync_fifo_pkg;

  // Indexed as {rd_acc, wr_acc}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int cnt_w(input int dep);
    return $clog2(dep + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_flags_ptr.sv
// fifo_wrap_ptr: FIFO address pointer wrapping from DEP-1 to 0 for any depth.
// Revision 1.0
`default_nettype none

module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEP = 4,
  localparam int PW = $clog2(DEP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEP - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags, error flags, FWFT/registered read.
// Revision 1.0 -- SYNC_FIFO_ERR_STICKY_EN adds err_clr_i and makes error flags sticky.
`default_nettype none

module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DEP    = 4,
  parameter int DWID   = 16,
  parameter int AF_THR = DEP - 1,
  parameter int AE_THR = 1,
  parameter int FWFT   = 1,
  localparam int CW    = cnt_w(DEP),
  localparam int PW    = $clog2(DEP)
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SYNC_FIFO_ERR_STICKY_EN
  input  logic            err_clr_i,
`endif
  input  logic            wr_i,
  input  logic [DWID-1:0] wdata,
  input  logic            rd_i,
  output logic [DWID-1:0] rdata,
  output logic            rvalid_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            afull_o,
  output logic            aempty_o,
  output logic [CW-1:0]   count_o,
  output logic            ovf_err_o,
  output logic            udf_err_o
);

  localparam logic [CW-1:0] DEP_C = CW'(DEP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_THR);
  localparam logic [CW-1:0] AE_C  = CW'(AE_THR);

  logic [DWID-1:0] mem [DEP];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            wr_acc;
  logic            rd_acc;
  logic            ovf_ev;
  logic            udf_ev;
  fifo_op_e        op;
  logic [CW-1:0]   count_nxt;

  // Accept decisions look only at registered flags.
  assign wr_acc = wr_i & ~full_o;
  assign rd_acc = rd_i & ~empty_o;
  assign ovf_ev = wr_i & full_o;
  assign udf_ev = rd_i & empty_o;

  always_comb begin
    op        = fifo_op_e'({rd_acc, wr_acc});
    count_nxt = count_o;
    case (op)
      OP_WR:   count_nxt = count_o + CW'(1);
      OP_RD:   count_nxt = count_o - CW'(1);
      default: count_nxt = count_o;
    endcase
  end

  fifo_wrap_ptr #(.DEP(DEP)) u_wptr (.clk(clk), .rst(rst), .inc(wr_acc), .ptr(wptr));
  fifo_wrap_ptr #(.DEP(DEP)) u_rptr (.clk(clk), .rst(rst), .inc(rd_acc), .ptr(rptr));

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  // Flags are registered from the next count so they always agree with count_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_o  <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
      afull_o  <= 1'b0;
      aempty_o <= 1'b1;
    end else begin
      count_o  <= count_nxt;
      full_o   <= (count_nxt == DEP_C);
      empty_o  <= (count_nxt == '0);
      afull_o  <= (count_nxt >= AF_C);
      aempty_o <= (count_nxt <= AE_C);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err_o <= 1'b0;
      udf_err_o <= 1'b0;
    end else begin
`ifdef SYNC_FIFO_ERR_STICKY_EN
      ovf_err_o <= ovf_ev | (ovf_err_o & ~err_clr_i);
      udf_err_o <= udf_ev | (udf_err_o & ~err_clr_i);
`else
      ovf_err_o <= ovf_ev;
      udf_err_o <= udf_ev;
`endif
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Mask the unreset memory so rdata reads zero while nothing is stored.
      assign rdata    = empty_o ? '0 : mem[rptr];
      assign rvalid_o = ~empty_o;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata    <= '0;
          rvalid_o <= 1'b0;
        end else begin
          rvalid_o <= rd_acc;
          if (rd_acc) begin
            rdata <= mem[rptr];
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
